// File: rtl/filter_pkg.sv
// Shared definitions for the UART sample filter: pairing FSM encoding and
// default configuration values.
package filter_pkg;

    typedef enum logic {
        WAIT_LOW  = 1'b0,
        WAIT_HIGH = 1'b1
    } pairState_e;

    localparam int TIMEOUT_CLKS_DEFAULT = 56260;
    localparam int LOG2_TAPS_DEFAULT    = 2;

endpackage

// File: rtl/sample_avg.sv
// Moving average over the last 2**LOG2_TAPS raw samples, kept as a running sum
// over a circular delay line; the result is registered one cycle after i_valid.
module sample_avg
    import filter_pkg::*;
#(
    parameter int LOG2_TAPS = LOG2_TAPS_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [15:0] i_sample,
    output logic [15:0] o_avg,
    output logic        o_avg_valid
);

    localparam int TAPS = 1 << LOG2_TAPS;
    localparam int SW   = 16 + LOG2_TAPS;
    localparam logic [LOG2_TAPS:0] FULL = (LOG2_TAPS + 1)'(TAPS);

    logic [15:0]          line_q [TAPS];
    logic [LOG2_TAPS-1:0] ptr_q;
    logic [LOG2_TAPS:0]   fill_q;
    logic [SW-1:0]        sum_q;
    logic [SW-1:0]        sum_d;
    logic [SW-1:0]        newExt;
    logic [SW-1:0]        oldest;
    logic [15:0]          avg_q;
    logic                 valid_q;

    // Slots not yet written since reset contribute zero to the sum.
    always_comb begin
        newExt = {{LOG2_TAPS{i_sample[15]}}, i_sample};
        oldest = '0;
        if (fill_q == FULL) begin
            oldest = {{LOG2_TAPS{line_q[ptr_q][15]}}, line_q[ptr_q]};
        end
        sum_d = sum_q + newExt - oldest;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                line_q[i] <= '0;
            end
            ptr_q   <= '0;
            fill_q  <= '0;
            sum_q   <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= i_valid;
            if (i_valid) begin
                line_q[ptr_q] <= i_sample;
                ptr_q         <= ptr_q + 1'b1;
                sum_q         <= sum_d;
                // Dropping the low bits of the signed sum floors toward -inf.
                avg_q         <= sum_d[SW-1:LOG2_TAPS];
                if (fill_q != FULL) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
        end
    end

    assign o_avg       = avg_q;
    assign o_avg_valid = valid_q;

endmodule

// File: rtl/rx_sample_filter.sv
// Pairs UART bytes little-endian into signed 16-bit samples and smooths them.
// Define RX_FILTER_TIMEOUT_EN to drop a stale low byte after TIMEOUT_CLKS idle clocks.
module rx_sample_filter
    import filter_pkg::*;
#(
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT,
    parameter int LOG2_TAPS    = LOG2_TAPS_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  i_data_byte,
    input  logic        i_data_avail,
    output logic [15:0] o_sample,
    output logic        o_sample_valid,
    output logic        o_resync
);

    pairState_e  state_q, state_d;
    logic [7:0]  lowByte_q, lowByte_d;
    logic        sampleStrobe;
    logic [15:0] rawSample;

`ifdef RX_FILTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             resync_q, resync_d;
`endif

    // A strobe always wins over a coincident timeout in WAIT_HIGH.
    always_comb begin
        state_d   = state_q;
        lowByte_d = lowByte_q;
`ifdef RX_FILTER_TIMEOUT_EN
        count_d   = count_q;
        resync_d  = 1'b0;
`endif
        case (state_q)
            WAIT_LOW: begin
                if (i_data_avail) begin
                    lowByte_d = i_data_byte;
                    state_d   = WAIT_HIGH;
`ifdef RX_FILTER_TIMEOUT_EN
                    count_d   = '0;
`endif
                end
            end
            WAIT_HIGH: begin
                if (i_data_avail) begin
                    state_d = WAIT_LOW;
`ifdef RX_FILTER_TIMEOUT_EN
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d   = WAIT_LOW;
                    lowByte_d = '0;
                    count_d   = '0;
                    resync_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
`endif
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= WAIT_LOW;
            lowByte_q <= '0;
`ifdef RX_FILTER_TIMEOUT_EN
            count_q   <= '0;
            resync_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            lowByte_q <= lowByte_d;
`ifdef RX_FILTER_TIMEOUT_EN
            count_q   <= count_d;
            resync_q  <= resync_d;
`endif
        end
    end

    assign sampleStrobe = (state_q == WAIT_HIGH) && i_data_avail;
    assign rawSample    = {i_data_byte, lowByte_q};

`ifdef RX_FILTER_TIMEOUT_EN
    assign o_resync = resync_q;
`else
    assign o_resync = 1'b0;
`endif

    sample_avg #(
        .LOG2_TAPS(LOG2_TAPS)
    ) u_avg (
        .clock      (clock),
        .reset      (reset),
        .i_valid    (sampleStrobe),
        .i_sample   (rawSample),
        .o_avg      (o_sample),
        .o_avg_valid(o_sample_valid)
    );

endmodule
